// File: rtl/move_controller_pkg.sv
// Shared display geometry and coordinate widths for the sprite pipeline
// (sync generator, display controller, move controller).
package move_controller_pkg;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned COORD_X_W = 10;
  localparam int unsigned COORD_Y_W = 9;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_DEC,
    DIR_INC
  } dir_e;

  // Opposing buttons cancel; a lone button selects its direction.
  function automatic dir_e axis_dir(input logic dec, input logic inc);
    if (dec && !inc)      return DIR_DEC;
    else if (inc && !dec) return DIR_INC;
    else                  return DIR_NONE;
  endfunction

endpackage

// File: rtl/move_controller_btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-disagreement counter;
// the stable level flips only after DEBOUNCE_CYCLES disagreeing cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/move_controller.sv
// Sprite position controller: debounced buttons move the sprite by STEP
// pixels once per frame, clamped to the visible area.
module move_controller #(
  parameter int unsigned H_ACTIVE        = move_controller_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE        = move_controller_pkg::V_ACTIVE,
  parameter int unsigned SPRITE_W        = 32,
  parameter int unsigned SPRITE_H        = 32,
  parameter int unsigned STEP            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned INIT_X          = 304,
  parameter int unsigned INIT_Y          = 224
) (
  input  logic                                  iVGA_CLK,
  input  logic                                  iRST,
  input  logic                                  iVS,
  input  logic                                  iMoveUp,
  input  logic                                  iMoveDown,
  input  logic                                  iMoveLeft,
  input  logic                                  iMoveRight,
  output logic [move_controller_pkg::COORD_X_W-1:0] oCoordX,
  output logic [move_controller_pkg::COORD_Y_W-1:0] oCoordY,
  output logic                                  oFrameTick
);

  import move_controller_pkg::*;

  localparam int unsigned XW1 = COORD_X_W + 1;
  localparam int unsigned YW1 = COORD_Y_W + 1;

  localparam logic [XW1-1:0]       X_MAX_W  = XW1'(H_ACTIVE - SPRITE_W);
  localparam logic [YW1-1:0]       Y_MAX_W  = YW1'(V_ACTIVE - SPRITE_H);
  localparam logic [XW1-1:0]       STEP_XW  = XW1'(STEP);
  localparam logic [YW1-1:0]       STEP_YW  = YW1'(STEP);
  localparam logic [COORD_X_W-1:0] STEP_XN  = COORD_X_W'(STEP);
  localparam logic [COORD_Y_W-1:0] STEP_YN  = COORD_Y_W'(STEP);
  localparam logic [COORD_X_W-1:0] X_MAX_N  = COORD_X_W'(H_ACTIVE - SPRITE_W);
  localparam logic [COORD_Y_W-1:0] Y_MAX_N  = COORD_Y_W'(V_ACTIVE - SPRITE_H);
  localparam logic [COORD_X_W-1:0] INIT_X_N = COORD_X_W'(INIT_X);
  localparam logic [COORD_Y_W-1:0] INIT_Y_N = COORD_Y_W'(INIT_Y);

  // Bit order: 0 up, 1 down, 2 left, 3 right.
  logic [3:0] w_btn_raw;
  logic [3:0] w_lvl;

  assign w_btn_raw = {iMoveRight, iMoveLeft, iMoveDown, iMoveUp};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (iVGA_CLK),
      .i_rst  (iRST),
      .i_btn  (w_btn_raw[g]),
      .o_level(w_lvl[g])
    );
  end

  logic                 r_vs_prev;
  logic                 r_tick;
  logic [COORD_X_W-1:0] r_x;
  logic [COORD_Y_W-1:0] r_y;

  logic [XW1-1:0]       w_x_wide, w_x_sum;
  logic [YW1-1:0]       w_y_wide, w_y_sum;
  logic [COORD_X_W-1:0] w_x_next;
  logic [COORD_Y_W-1:0] w_y_next;

  assign w_x_wide = {1'b0, r_x};
  assign w_y_wide = {1'b0, r_y};
  assign w_x_sum  = w_x_wide + STEP_XW;
  assign w_y_sum  = w_y_wide + STEP_YW;

  // Decrement is guarded before subtracting, increment compared at full width.
  always_comb begin
    w_x_next = r_x;
    case (axis_dir(w_lvl[2], w_lvl[3]))
      DIR_DEC: w_x_next = (w_x_wide < STEP_XW) ? '0 : (r_x - STEP_XN);
      DIR_INC: w_x_next = (w_x_sum > X_MAX_W) ? X_MAX_N : (r_x + STEP_XN);
      default: w_x_next = r_x;
    endcase
  end

  always_comb begin
    w_y_next = r_y;
    case (axis_dir(w_lvl[0], w_lvl[1]))
      DIR_DEC: w_y_next = (w_y_wide < STEP_YW) ? '0 : (r_y - STEP_YN);
      DIR_INC: w_y_next = (w_y_sum > Y_MAX_W) ? Y_MAX_N : (r_y + STEP_YN);
      default: w_y_next = r_y;
    endcase
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_vs_prev <= 1'b1;
      r_tick    <= 1'b0;
      r_x       <= INIT_X_N;
      r_y       <= INIT_Y_N;
    end else begin
      r_vs_prev <= iVS;
      r_tick    <= r_vs_prev & ~iVS;
      if (r_tick) begin
        r_x <= w_x_next;
        r_y <= w_y_next;
      end
    end
  end

  assign oCoordX    = r_x;
  assign oCoordY    = r_y;
  assign oFrameTick = r_tick;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: two instances (default and near-edge start
// positions) compared every cycle against a history-based reference model.
module tb_move_controller;

  localparam int DB    = 4;
  localparam int STEPM = 4;
  localparam int XMAX  = 608;
  localparam int YMAX  = 448;

  logic       clk = 1'b0;
  logic       rst, vs, up, dn, lf, rt;
  logic [9:0] x_a, x_b;
  logic [8:0] y_a, y_b;
  logic       tk_a, tk_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  move_controller #(
    .DEBOUNCE_CYCLES(DB)
  ) u_dut (
    .iVGA_CLK  (clk),
    .iRST      (rst),
    .iVS       (vs),
    .iMoveUp   (up),
    .iMoveDown (dn),
    .iMoveLeft (lf),
    .iMoveRight(rt),
    .oCoordX   (x_a),
    .oCoordY   (y_a),
    .oFrameTick(tk_a)
  );

  move_controller #(
    .DEBOUNCE_CYCLES(DB),
    .INIT_X         (606),
    .INIT_Y         (2)
  ) u_dut_edge (
    .iVGA_CLK  (clk),
    .iRST      (rst),
    .iVS       (vs),
    .iMoveUp   (up),
    .iMoveDown (dn),
    .iMoveLeft (lf),
    .iMoveRight(rt),
    .oCoordX   (x_b),
    .oCoordY   (y_b),
    .oFrameTick(tk_b)
  );

  // Reference model: raw input samples since reset, button order up/down/left/right.
  bit raw_q[4][$];
  bit vs_q[$];
  bit m_db[4];
  bit m_tick;
  int m_x[2];
  int m_y[2];
  int init_x[2] = '{304, 606};
  int init_y[2] = '{224, 2};

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Synchronized level seen at edge k is the raw sample from two edges earlier.
  function automatic bit sync_seen(int b, int k);
    return (k >= 2) ? raw_q[b][k-2] : 1'b0;
  endfunction

  function automatic int step_axis(int c, bit dec, bit inc, int maxv);
    int n;
    n = c;
    if (dec && !inc)      n = c - STEPM;
    else if (inc && !dec) n = c + STEPM;
    if (n < 0)    n = 0;
    if (n > maxv) n = maxv;
    return n;
  endfunction

  task automatic model_edge();
    bit raw[4];
    int k;
    bit flip;
    raw = '{up, dn, lf, rt};
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        raw_q[b].delete();
        m_db[b] = 1'b0;
      end
      vs_q.delete();
      m_tick = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_x[d] = init_x[d];
        m_y[d] = init_y[d];
      end
      return;
    end
    k = vs_q.size();
    if (m_tick) begin
      for (int d = 0; d < 2; d++) begin
        m_y[d] = step_axis(m_y[d], m_db[0], m_db[1], YMAX);
        m_x[d] = step_axis(m_x[d], m_db[2], m_db[3], XMAX);
      end
    end
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++)
        if (k - j < 0 || sync_seen(b, k - j) == m_db[b]) flip = 1'b0;
      if (flip) m_db[b] = !m_db[b];
    end
    m_tick = ((k == 0) ? 1'b1 : vs_q[k-1]) && !vs;
    for (int b = 0; b < 4; b++) raw_q[b].push_back(raw[b]);
    vs_q.push_back(vs);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_val("a_x", int'(x_a), m_x[0]);
    check_val("a_y", int'(y_a), m_y[0]);
    check_val("a_tick", int'(tk_a), int'(m_tick));
    check_val("b_x", int'(x_b), m_x[1]);
    check_val("b_y", int'(y_b), m_y[1]);
    check_val("b_tick", int'(tk_b), int'(m_tick));
  endtask

  task automatic frame(input int len);
    vs = 1'b1;
    repeat (len - 2) cyc();
    vs = 1'b0;
    repeat (2) cyc();
    vs = 1'b1;
  endtask

  initial begin
    int vcnt;
    vcnt = 0;
    rst = 1'b1; vs = 1'b1; up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    repeat (3) frame(16);

    rt = 1'b1;
    repeat (4) frame(16);
    rt = 1'b0;
    repeat (2) frame(16);

    up = 1'b1;
    repeat (2) frame(16);
    up = 1'b0;
    frame(16);

    up = 1'b1; dn = 1'b1; lf = 1'b1;
    frame(16);
    up = 1'b0; dn = 1'b0; lf = 1'b0;
    frame(16);

    for (int i = 0; i < 4; i++) begin
      rt = (i % 2 == 0);
      repeat (3) cyc();
    end
    rt = 1'b1;
    repeat (8) cyc();
    frame(16);
    rt = 1'b0;
    frame(16);

    // Reset lands on the cycle the frame tick is high, with a press held.
    rt = 1'b1;
    repeat (10) cyc();
    vs = 1'b0;
    cyc();
    rst = 1'b1; vs = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (2) frame(16);
    rt = 1'b0;
    frame(16);

    for (int c = 0; c < 3000; c++) begin
      if (vcnt == 0) vcnt = $urandom_range(30, 12);
      vs = (vcnt <= 2) ? 1'b0 : 1'b1;
      vcnt--;
      if ($urandom_range(15, 0) == 0) up = ~up;
      if ($urandom_range(15, 0) == 0) dn = ~dn;
      if ($urandom_range(15, 0) == 0) lf = ~lf;
      if ($urandom_range(15, 0) == 0) rt = ~rt;
      rst = ($urandom_range(499, 0) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
